// File: rtl/tff_bank_sequencer.sv
// tff_bank_sequencer: command-driven sequencer driving toggle enables into an internal T flip-flop bank.
// Define TFF_SEQ_DOWN_EN to enable op 11 COUNT_DOWN; otherwise op 11 completes without touching the bank.
module tff_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_steps,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] op;
    logic [WIDTH-1:0] mask, down_vec;
    logic [CNT_W-1:0] rem;
    logic supported, skip;
`ifdef TFF_SEQ_DOWN_EN
    assign supported = 1'b1;
    assign down_vec = q ^ (q - WIDTH'(1));
`else
    assign supported = cmd_op != 2'b11;
    assign down_vec = '0;
`endif
    assign skip = (cmd_op[1] && cmd_steps == '0) || !supported;
    assign cmd_ready = state == IDLE;
    assign busy = state != IDLE;
    assign done = state == DONE;
    // q ^ (q +/- 1) is exactly the set of bits a synchronous up/down counter toggles
    always_comb begin
        state_nx = state;
        t_vec = '0;
        case (state)
            IDLE: state_nx = cmd_valid ? (skip ? DONE : RUN) : IDLE;
            RUN: begin
                t_vec = op == 2'b00 ? q :
                        op == 2'b01 ? mask :
                        op == 2'b10 ? q ^ (q + WIDTH'(1)) : down_vec;
                state_nx = (op[1] && rem != CNT_W'(1)) ? RUN : DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            q <= '0;
            op <= '0;
            mask <= '0;
            rem <= '0;
        end else begin
            state <= state_nx;
            q <= q ^ t_vec;
            if (state == IDLE && cmd_valid) begin
                op <= cmd_op;
                mask <= cmd_mask;
                rem <= cmd_steps;
            end else if (state == RUN) begin
                rem <= rem - CNT_W'(1);
            end
        end
    end
endmodule
